// File: rtl/uart_pkg.sv
// Constants and FSM encoding shared by the bridge's UART receiver and transmitter.
package uart_pkg;

    localparam int DATA_BITS       = 8;
    localparam int BAUD_TICK_COUNT = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } uart_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-stage synchroniser for the asynchronous rx line; flops reset to the idle-high level.
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= '1;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_reg[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversampled on the 16x baud strobe, start-glitch rejection,
// single-entry valid/ready holding register, framing and overrun pulses.
module uart_rx #(
    parameter int BAUD_TICK_COUNT = uart_pkg::BAUD_TICK_COUNT,
    parameter int SYNC_STAGES     = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_16x,
    input  logic       rx,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       overrun_err
);
    import uart_pkg::*;

    localparam int                CNT_W     = $clog2(BAUD_TICK_COUNT);
    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(BAUD_TICK_COUNT / 2 - 1);
    localparam logic [CNT_W-1:0]  FULL_LAST = CNT_W'(BAUD_TICK_COUNT - 1);
    localparam logic [2:0]        LAST_BIT  = 3'(DATA_BITS - 1);

    logic                 rx_s;
    logic                 clk_16x_d_reg;
    logic                 tick;
    uart_state_t          state_reg, state_next;
    logic [CNT_W-1:0]     tick_cnt_reg, tick_cnt_next;
    logic [2:0]           bit_idx_reg, bit_idx_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic                 stop_sample, stop_ok, stop_bad;
    logic                 deliver_reg, frame_err_reg, overrun_err_reg, rx_valid_reg;
    logic [DATA_BITS-1:0] rx_data_reg;

    uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    assign tick = clk_16x & ~clk_16x_d_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_16x_d_reg <= 1'b0;
            state_reg     <= IDLE;
            tick_cnt_reg  <= '0;
            bit_idx_reg   <= '0;
            shift_reg     <= '0;
        end else begin
            clk_16x_d_reg <= clk_16x;
            state_reg     <= state_next;
            tick_cnt_reg  <= tick_cnt_next;
            bit_idx_reg   <= bit_idx_next;
            shift_reg     <= shift_next;
        end
    end

    // All sample points are counted from the tick that first saw the start edge.
    always_comb begin
        state_next    = state_reg;
        tick_cnt_next = tick_cnt_reg;
        bit_idx_next  = bit_idx_reg;
        shift_next    = shift_reg;
        if (tick) begin
            case (state_reg)
                IDLE: begin
                    if (!rx_s) begin
                        state_next    = START;
                        tick_cnt_next = '0;
                    end
                end
                START: begin
                    if (tick_cnt_reg == HALF_LAST) begin
                        tick_cnt_next = '0;
                        bit_idx_next  = '0;
                        state_next    = rx_s ? IDLE : DATA;
                    end else begin
                        tick_cnt_next = tick_cnt_reg + 1'b1;
                    end
                end
                DATA: begin
                    if (tick_cnt_reg == FULL_LAST) begin
                        tick_cnt_next = '0;
                        shift_next    = {rx_s, shift_reg[DATA_BITS-1:1]};
                        if (bit_idx_reg == LAST_BIT) begin
                            state_next = STOP;
                        end else begin
                            bit_idx_next = bit_idx_reg + 3'd1;
                        end
                    end else begin
                        tick_cnt_next = tick_cnt_reg + 1'b1;
                    end
                end
                STOP: begin
                    if (tick_cnt_reg == FULL_LAST) begin
                        tick_cnt_next = '0;
                        state_next    = rx_s ? IDLE : WAIT_IDLE;
                    end else begin
                        tick_cnt_next = tick_cnt_reg + 1'b1;
                    end
                end
                WAIT_IDLE: begin
                    if (rx_s) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        stop_sample = tick && (state_reg == STOP) && (tick_cnt_reg == FULL_LAST);
        stop_ok     = stop_sample && rx_s;
        stop_bad    = stop_sample && !rx_s;
        rx_busy     = (state_reg != IDLE);
    end

    // A completed byte waits one clk in shift_reg; it lands only if the slot is free or being drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deliver_reg     <= 1'b0;
            frame_err_reg   <= 1'b0;
            overrun_err_reg <= 1'b0;
            rx_valid_reg    <= 1'b0;
            rx_data_reg     <= '0;
        end else begin
            deliver_reg     <= stop_ok;
            frame_err_reg   <= stop_bad;
            overrun_err_reg <= 1'b0;
            if (deliver_reg) begin
                if (!rx_valid_reg || rx_ready) begin
                    rx_data_reg  <= shift_reg;
                    rx_valid_reg <= 1'b1;
                end else begin
                    overrun_err_reg <= 1'b1;
                end
            end else if (rx_valid_reg && rx_ready) begin
                rx_valid_reg <= 1'b0;
            end
        end
    end

    assign rx_data     = rx_data_reg;
    assign rx_valid    = rx_valid_reg;
    assign frame_err   = frame_err_reg;
    assign overrun_err = overrun_err_reg;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed scenarios plus random frames, every output checked
// each clk against a tick-offset reference model of the receiver.
module tb_uart_rx;

    localparam int B        = 16;
    localparam int SYNC     = 2;
    localparam int DIV      = 4;
    localparam int BIT_CLKS = B * DIV;
    localparam int HALF     = B / 2;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       clk_16x  = 1'b0;
    logic       rx       = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       frame_err;
    logic       overrun_err;

    uart_rx #(.BAUD_TICK_COUNT(B), .SYNC_STAGES(SYNC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clk_16x     (clk_16x),
        .rx          (rx),
        .rx_ready    (rx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_busy     (rx_busy),
        .frame_err   (frame_err),
        .overrun_err (overrun_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // 16x strobe: high for half of every DIV clks
    int ph = 0;
    initial begin
        forever begin
            @(negedge clk);
            ph      = (ph + 1) % DIV;
            clk_16x = (ph < DIV / 2);
        end
    end

    // Reference model: sample points derived as tick offsets from the detecting tick.
    logic [SYNC-1:0] m_sync;
    logic            m_s16_prev, m_busy, m_wait, m_pend, m_valid, m_ferr, m_ovr;
    logic [7:0]      m_data, m_byte, m_pend_byte;
    int              tn, det;

    initial begin
        int   rel, k;
        logic line, tick;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                m_sync = '1; m_s16_prev = 1'b0; m_busy = 1'b0; m_wait = 1'b0;
                m_pend = 1'b0; m_pend_byte = 8'h00; m_byte = 8'h00;
                m_valid = 1'b0; m_data = 8'h00; m_ferr = 1'b0; m_ovr = 1'b0;
                tn = 0; det = 0;
            end else begin
                line       = m_sync[SYNC-1];
                m_sync     = {m_sync[SYNC-2:0], rx};
                tick       = clk_16x && !m_s16_prev;
                m_s16_prev = clk_16x;
                m_ferr     = 1'b0;
                m_ovr      = 1'b0;
                if (m_pend) begin
                    if (!m_valid || rx_ready) begin
                        m_data  = m_pend_byte;
                        m_valid = 1'b1;
                    end else begin
                        m_ovr = 1'b1;
                    end
                end else if (m_valid && rx_ready) begin
                    m_valid = 1'b0;
                end
                m_pend = 1'b0;
                if (tick) begin
                    tn++;
                    if (!m_busy) begin
                        if (!line) begin
                            m_busy = 1'b1; m_wait = 1'b0; det = tn;
                        end
                    end else if (m_wait) begin
                        if (line) begin
                            m_busy = 1'b0; m_wait = 1'b0;
                        end
                    end else begin
                        rel = tn - det;
                        if (rel == HALF) begin
                            if (line) m_busy = 1'b0;
                        end else if (rel > HALF && (rel - HALF) % B == 0) begin
                            k = (rel - HALF) / B;
                            if (k <= 8) begin
                                m_byte[k-1] = line;
                            end else if (line) begin
                                m_pend = 1'b1; m_pend_byte = m_byte; m_busy = 1'b0;
                            end else begin
                                m_ferr = 1'b1; m_wait = 1'b1;
                            end
                        end
                    end
                end
            end
        end
    end

    // Per-cycle compare plus event bookkeeping for the directed checks.
    logic       pv = 1'b0, pb = 1'b0;
    int         vrun = 0, last_vrun = 0, busy_rise = 0, busy_len = 0;
    int         ferr_cnt = 0, ovr_cnt = 0, n_dly = 0;
    logic [7:0] last_dly_data = 8'h00;
    int         dly_cyc[$];
    logic [7:0] dly_data[$];

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                chk("reset_rx_data", rx_data, 8'h00);
                chk("reset_rx_valid", rx_valid, 1'b0);
                chk("reset_rx_busy", rx_busy, 1'b0);
                chk("reset_frame_err", frame_err, 1'b0);
                chk("reset_overrun_err", overrun_err, 1'b0);
            end else begin
                chk("rx_data", rx_data, m_data);
                chk("rx_valid", rx_valid, m_valid);
                chk("rx_busy", rx_busy, m_busy);
                chk("frame_err", frame_err, m_ferr);
                chk("overrun_err", overrun_err, m_ovr);
            end
            if (rx_valid && !pv) begin
                n_dly++;
                last_dly_data = rx_data;
                dly_cyc.push_back(cyc);
                dly_data.push_back(rx_data);
                $display("rx delivery %0d: data=0x%02h cycle=%0d", n_dly, rx_data, cyc);
            end
            if (rx_valid) begin
                vrun++;
            end else if (pv) begin
                last_vrun = vrun;
                vrun      = 0;
            end
            if (rx_busy && !pb) busy_rise = cyc;
            if (!rx_busy && pb) busy_len = cyc - busy_rise;
            ferr_cnt += int'(frame_err);
            ovr_cnt  += int'(overrun_err);
            pv = rx_valid;
            pb = rx_busy;
        end
    end

    logic rand_ready = 1'b0;
    int   n_frames   = 0;

    task automatic wait_clks(input int n);
        repeat (n) begin
            @(negedge clk);
            if (rand_ready) rx_ready = ($urandom_range(0, 2) == 0);
        end
    endtask

    task automatic drive_bit(input logic b, input int nclks);
        rx = b;
        wait_clks(nclks);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        n_frames++;
        $display("tx frame %0d: data=0x%02h stop=%0b", n_frames, d, stop);
        drive_bit(1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) drive_bit(d[i], BIT_CLKS);
        drive_bit(stop, BIT_CLKS);
    endtask

    initial begin
        int         d0, f0, o0, sp;
        logic [7:0] rb;
        logic [7:0] c3;
        logic       rs;

        rst_n = 1'b0; rx = 1'b1; rx_ready = 1'b0;
        wait_clks(6);
        rst_n = 1'b1;
        wait_clks(2 * BIT_CLKS);

        // single frame, consumer always ready
        rx_ready = 1'b1; d0 = n_dly; f0 = ferr_cnt; o0 = ovr_cnt;
        send_frame(8'hA5, 1'b1);
        wait_clks(BIT_CLKS);
        chk("t1_count", n_dly - d0, 1);
        chk("t1_data", last_dly_data, 8'hA5);
        chk("t1_valid_len", last_vrun, 1);
        chk("t1_busy_len", busy_len, (HALF + 9 * B) * DIV);
        chk("t1_errs", (ferr_cnt - f0) + (ovr_cnt - o0), 0);

        // start glitch of 4 ticks
        d0 = n_dly; f0 = ferr_cnt;
        drive_bit(1'b0, 4 * DIV);
        drive_bit(1'b1, 3 * BIT_CLKS);
        chk("t2_busy_len", busy_len, HALF * DIV);
        chk("t2_no_delivery", n_dly - d0, 0);
        chk("t2_no_ferr", ferr_cnt - f0, 0);
        chk("t2_busy_idle", rx_busy, 1'b0);

        // bad stop, line held low, then a good frame
        d0 = n_dly; f0 = ferr_cnt;
        send_frame(8'h3C, 1'b0);
        drive_bit(1'b0, 30 * DIV);
        chk("t3_ferr", ferr_cnt - f0, 1);
        chk("t3_no_delivery", n_dly - d0, 0);
        chk("t3_wait_busy", rx_busy, 1'b1);
        drive_bit(1'b1, 2 * BIT_CLKS);
        chk("t3_released", rx_busy, 1'b0);
        send_frame(8'h5A, 1'b1);
        wait_clks(BIT_CLKS);
        chk("t3_next_data", last_dly_data, 8'h5A);
        chk("t3_next_count", n_dly - d0, 1);

        // overrun with consumer stalled
        rx_ready = 1'b0; d0 = n_dly; o0 = ovr_cnt;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        wait_clks(BIT_CLKS);
        chk("t4_data", rx_data, 8'h11);
        chk("t4_valid_held", rx_valid, 1'b1);
        chk("t4_overrun", ovr_cnt - o0, 1);
        chk("t4_one_delivery", n_dly - d0, 1);
        rx_ready = 1'b1;
        wait_clks(1);
        chk("t4_valid_cleared", rx_valid, 1'b0);

        // back-to-back frames with no idle gap
        d0 = n_dly;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        wait_clks(BIT_CLKS);
        chk("t5_count", n_dly - d0, 2);
        if (n_dly - d0 >= 2) begin
            chk("t5_first", dly_data[d0], 8'h00);
            chk("t5_second", dly_data[d0+1], 8'hFF);
            sp = dly_cyc[d0+1] - dly_cyc[d0];
            n_cmp++;
            if (sp < 10 * BIT_CLKS - DIV || sp > 10 * BIT_CLKS + DIV) begin
                n_bad++;
                $display("FAIL t5_spacing: got %0d clks, expected %0d +/- %0d", sp, 10 * BIT_CLKS, DIV);
            end
        end

        // reset during bit 4 of 0xC3
        d0 = n_dly; c3 = 8'hC3;
        $display("tx frame (aborted by reset): data=0x%02h", c3);
        drive_bit(1'b0, BIT_CLKS);
        for (int i = 0; i < 4; i++) drive_bit(c3[i], BIT_CLKS);
        rx = c3[4];
        wait_clks(BIT_CLKS / 2);
        chk("t6_busy_before_reset", rx_busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("t6_async_busy", rx_busy, 1'b0);
        chk("t6_async_valid", rx_valid, 1'b0);
        wait_clks(3);
        rst_n = 1'b1;
        rx    = 1'b1;
        wait_clks(2 * BIT_CLKS);
        chk("t6_no_delivery", n_dly - d0, 0);
        send_frame(8'h7E, 1'b1);
        wait_clks(BIT_CLKS);
        chk("t6_next_data", last_dly_data, 8'h7E);
        chk("t6_next_count", n_dly - d0, 1);

        // random frames, gaps, stop errors and consumer stalls
        rand_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            rb = 8'($urandom);
            rs = ($urandom_range(0, 4) != 0);
            send_frame(rb, rs);
            if (!rs) drive_bit(1'b0, $urandom_range(0, 20) * DIV);
            drive_bit(1'b1, $urandom_range(0, 80) + (rs ? 0 : BIT_CLKS));
        end
        rand_ready = 1'b0;
        rx_ready   = 1'b1;
        drive_bit(1'b1, 2 * BIT_CLKS);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
